// File: rtl/npc_ctrl.sv
// npc_ctrl: multi-cycle sequencer for the NPC core.
// Owns the PC and instruction register, fetches over a req/ready handshake,
// then walks each instruction through DECODE, EXEC, optional MEM and WB.
// Stops the core on ebreak, an illegal type code or a misaligned next PC.
//
// Handshake rule (imem and dmem alike): a request is decoded from the state
// register, so it stays high with its address/we stable until ready is
// sampled high on a rising edge; the transfer completes on that edge, and
// ready may arrive in the same cycle the request rises (zero-wait).
module npc_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h8000_0000,
  // Reset value of the retired counter; lets a bench start near the wrap.
  parameter logic [31:0] RETIRED_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic [2:0]  inst_type,
  input  logic        op_load,
  input  logic        op_store,
  input  logic        op_ebreak,
  input  logic [31:0] next_pc,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic [31:0] retired,
  output logic        halt,
  output logic [1:0]  halt_code
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] CODE_NONE      = 2'd0;
  localparam logic [1:0] CODE_EBREAK    = 2'd1;
  localparam logic [1:0] CODE_ILLEGAL   = 2'd2;
  localparam logic [1:0] CODE_MISALIGN  = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] pc_q, inst_q, retired_q;

  logic type_illegal;
  logic pc_misaligned;
  logic type_writes_rd;
  logic retire;

  // Type N (110) and the unused code 111 both halt the core.
  assign type_illegal   = inst_type[2] & inst_type[1];
  assign pc_misaligned  = |next_pc[1:0];
  // R, I, U and J write a destination register; S and B do not.
  assign type_writes_rd = (inst_type == 3'b000) || (inst_type == 3'b001) ||
                          (inst_type == 3'b100) || (inst_type == 3'b101);
  assign retire         = (state_q == S_WB) && !pc_misaligned;

  // Next-state and halt-code selection.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op_ebreak) begin
          state_d = S_HALT;
          code_d  = CODE_EBREAK;
        end else if (type_illegal) begin
          state_d = S_HALT;
          code_d  = CODE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_load || op_store) state_d = S_MEM;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) state_d = S_WB;
      end
      S_WB: begin
        if (pc_misaligned) begin
          state_d = S_HALT;
          code_d  = CODE_MISALIGN;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
        code_d  = CODE_ILLEGAL;
      end
    endcase
  end

  // State register and sticky halt code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      code_q  <= CODE_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  // Architectural registers: PC, instruction register, retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0000_0000;
      retired_q <= RETIRED_INIT;
    end else begin
      if (state_q == S_FETCH && imem_ready) inst_q <= imem_rdata;
      if (retire) begin
        pc_q      <= next_pc;
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  // Requests are gated by rst_n so they drop the instant reset asserts.
  assign imem_req  = rst_n && (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign dmem_req  = rst_n && (state_q == S_MEM);
  assign dmem_we   = rst_n && (state_q == S_MEM) && op_store;
  assign rf_we     = rst_n && retire && type_writes_rd;

  assign inst      = inst_q;
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign state     = state_q;
  assign halt      = (state_q == S_HALT);
  assign halt_code = code_q;

endmodule

// File: tb/tb_npc_ctrl.sv
// tb_npc_ctrl: self-checking bench for npc_ctrl. The bench plays the imem,
// the decoder, the EXU and the dmem; a small model predicts each
// instruction's outcome, pushes it into exp_q and compares once it is done.
module tb_npc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata, inst;
  logic [2:0]  inst_type;
  logic        op_load, op_store, op_ebreak;
  logic [31:0] next_pc;
  logic        dmem_req, dmem_we, dmem_ready, rf_we;
  logic [31:0] pc, retired;
  logic [2:0]  state;
  logic        halt;
  logic [1:0]  halt_code;

  // Second instance, counter preloaded to all-ones to exercise the wrap.
  logic        w_imem_req, w_dmem_req, w_dmem_we, w_rf_we, w_halt;
  logic [31:0] w_imem_addr, w_inst, w_pc, w_retired;
  logic [2:0]  w_state;
  logic [1:0]  w_halt_code;

  npc_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst(inst), .inst_type(inst_type),
    .op_load(op_load), .op_store(op_store), .op_ebreak(op_ebreak),
    .next_pc(next_pc), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .rf_we(rf_we), .pc(pc), .state(state),
    .retired(retired), .halt(halt), .halt_code(halt_code)
  );

  npc_ctrl #(.RESET_PC(RESET_PC), .RETIRED_INIT(32'hFFFF_FFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst(w_inst), .inst_type(inst_type),
    .op_load(op_load), .op_store(op_store), .op_ebreak(op_ebreak),
    .next_pc(next_pc), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
    .dmem_ready(dmem_ready), .rf_we(w_rf_we), .pc(w_pc), .state(w_state),
    .retired(w_retired), .halt(w_halt), .halt_code(w_halt_code)
  );

  // ---------------- scoreboard ----------------
  int chk_total = 0;
  int chk_pass  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc   = RESET_PC;
  logic [31:0] model_ret  = 32'd0;
  logic [31:0] wrap_model = 32'hFFFF_FFFF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_total++;
    if (got === exp) chk_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Called and returns on a falling edge.
  task automatic do_reset();
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    model_pc   = RESET_PC;
    model_ret  = 32'd0;
    wrap_model = 32'hFFFF_FFFF;
    #1;
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_rf_we",    {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    check("rst_state",    {29'd0, state}, 32'd0);
    check("rst_pc",       pc, RESET_PC);
    check("rst_inst",     inst, 32'd0);
    check("rst_retired",  retired, 32'd0);
    check("rst_halt",     {31'd0, halt}, 32'd0);
    check("rst_code",     {30'd0, halt_code}, 32'd0);
    check("rst_wrap_ret", w_retired, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_imem_req",  {31'd0, imem_req}, 32'd1);
    check("first_imem_addr", imem_addr, RESET_PC);
    check("first_halt",      {31'd0, halt}, 32'd0);
  endtask

  // Runs one instruction from FETCH until it returns to FETCH or halts.
  task automatic do_instr(input logic [31:0] word, input logic [2:0] typ,
                          input logic ld, input logic st, input logic eb,
                          input logic [31:0] npc, input int iw, input int dw);
    logic [1:0]  code;
    logic [31:0] cyc_exp;
    logic        rf_exp;
    logic [31:0] start_pc;
    logic [2:0]  st_now;
    int cyc = 0, iw_n = 0, dw_n = 0, rf_n = 0, rf_cyc = 0;
    bit done = 0;
    start_pc = model_pc;
    if (eb)                  code = 2'd1;
    else if (typ[2] & typ[1]) code = 2'd2;
    else if (npc[1:0] != 0)  code = 2'd3;
    else                     code = 2'd0;
    if (code == 2'd1 || code == 2'd2) cyc_exp = 32'(iw + 2);
    else cyc_exp = 32'(4 + iw + ((ld | st) ? 1 + dw : 0));
    rf_exp = (code == 2'd0) && (typ == 3'd0 || typ == 3'd1 || typ == 3'd4 || typ == 3'd5);
    exp_q.push_back(cyc_exp);
    exp_q.push_back({31'd0, rf_exp});
    exp_q.push_back(rf_exp ? cyc_exp : 32'd0);
    exp_q.push_back(code == 2'd0 ? npc : model_pc);
    exp_q.push_back(code == 2'd0 ? model_ret + 32'd1 : model_ret);
    exp_q.push_back({30'd0, code});
    exp_q.push_back(code == 2'd0 ? 32'd0 : 32'd5);
    if (code == 2'd0) begin
      model_pc   = npc;
      model_ret  = model_ret + 32'd1;
      wrap_model = wrap_model + 32'd1;
    end
    imem_rdata = word; inst_type = typ;
    op_load = ld; op_store = st; op_ebreak = eb; next_pc = npc;
    while (!done && cyc < 40) begin
      cyc++;
      st_now = state;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      if (rf_we) begin rf_n++; rf_cyc = cyc; end
      case (st_now)
        3'd0: begin
          check("fetch_req",  {31'd0, imem_req}, 32'd1);
          check("fetch_addr", imem_addr, start_pc);
          imem_ready = (iw_n == iw);
          iw_n++;
        end
        3'd1: check("decode_inst", inst, word);
        3'd3: begin
          check("mem_req", {31'd0, dmem_req}, 32'd1);
          check("mem_we",  {31'd0, dmem_we}, {31'd0, st});
          dmem_ready = (dw_n == dw);
          dw_n++;
        end
        default: ;
      endcase
      @(posedge clk);
      @(negedge clk);
      if (state == 3'd5 || st_now == 3'd4) done = 1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    check("cycles",    32'(cyc),    exp_q.pop_front());
    check("rf_pulses", 32'(rf_n),   exp_q.pop_front());
    check("rf_cycle",  32'(rf_cyc), exp_q.pop_front());
    check("pc",        pc,          exp_q.pop_front());
    check("retired",   retired,     exp_q.pop_front());
    check("halt_code", {30'd0, halt_code}, exp_q.pop_front());
    check("state_end", {29'd0, state}, exp_q.pop_front());
    check("halt",      {31'd0, halt}, {31'd0, code != 2'd0});
    check("wrap_retired", w_retired, wrap_model);
  endtask

  // Once halted, ready pulses must have no effect.
  task automatic halted_idle(input logic [1:0] code);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      @(negedge clk);
      check("halt_state",    {29'd0, state}, 32'd5);
      check("halt_imem_req", {31'd0, imem_req}, 32'd0);
      check("halt_dmem_req", {31'd0, dmem_req}, 32'd0);
      check("halt_rf_we",    {31'd0, rf_we}, 32'd0);
      check("halt_pc",       pc, model_pc);
      check("halt_hold",     {30'd0, halt_code}, {30'd0, code});
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  typ;
    logic        ld, st;
    logic [31:0] npc, off;
    imem_ready = 0; dmem_ready = 0; imem_rdata = 0; inst_type = 0;
    op_load = 0; op_store = 0; op_ebreak = 0; next_pc = 0;
    @(negedge clk);
    do_reset();

    // addi, zero-wait
    do_instr(32'h0010_0093, 3'b001, 0, 0, 0, model_pc + 32'd4, 0, 0);
    // load with waits on both memories
    do_instr(32'h0000_2103, 3'b001, 1, 0, 0, model_pc + 32'd4, 2, 2);
    // store, then backward branch
    do_instr(32'h0020_2023, 3'b010, 0, 1, 0, model_pc + 32'd4, 1, 0);
    do_instr(32'hFE00_0CE3, 3'b011, 0, 0, 0, model_pc - 32'd8, 0, 0);
    // U and J types, then a random mix
    do_instr(32'h0000_0137, 3'b100, 0, 0, 0, model_pc + 32'd4, 0, 0);
    do_instr(32'h0080_006F, 3'b101, 0, 0, 0, model_pc + 32'd8, 0, 0);
    for (int i = 0; i < 10; i++) begin
      typ = 3'($urandom_range(0, 5));
      ld  = (typ == 3'b001) ? 1'($urandom_range(0, 1)) : 1'b0;
      st  = (typ == 3'b010);
      off = 32'($urandom_range(0, 63)) << 2;
      npc = ($urandom_range(0, 1) == 1) ? model_pc + 32'd4 : model_pc - 32'd128 + off;
      do_instr($urandom, typ, ld, st, 0, npc, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // halt on ebreak
    do_instr(32'h0010_0073, 3'b001, 0, 0, 1, model_pc + 32'd4, 1, 0);
    halted_idle(2'd1);
    do_reset();
    // halt on type N and on 111
    do_instr(32'h0000_0000, 3'b110, 0, 0, 0, model_pc + 32'd4, 0, 0);
    halted_idle(2'd2);
    do_reset();
    do_instr(32'hFFFF_FFFF, 3'b111, 0, 0, 0, model_pc + 32'd4, 0, 0);
    halted_idle(2'd2);
    do_reset();
    // halt on misaligned next PC
    do_instr(32'h0020_0093, 3'b001, 0, 0, 0, 32'h8000_0002, 0, 0);
    halted_idle(2'd3);
    do_reset();

    // one retirement so the pc has moved, then reset during MEM
    do_instr(32'h0010_0093, 3'b000, 0, 0, 0, model_pc + 32'd12, 0, 0);
    imem_rdata = 32'h0000_2103; inst_type = 3'b001;
    op_load = 1; op_store = 0; op_ebreak = 0; next_pc = model_pc + 32'd4;
    for (int i = 0; i < 10 && state != 3'd3; i++) begin
      imem_ready = (state == 3'd0);
      @(posedge clk);
      @(negedge clk);
    end
    imem_ready = 1'b0;
    check("mid_in_mem",  {29'd0, state}, 32'd3);
    check("mid_dmem_req", {31'd0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_dmem_drop", {31'd0, dmem_req}, 32'd0);
    check("mid_state",     {29'd0, state}, 32'd0);
    check("mid_pc",        pc, RESET_PC);
    @(negedge clk);
    do_reset();
    do_instr(32'h0010_0093, 3'b001, 0, 0, 0, model_pc + 32'd4, 0, 1);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed so far", chk_pass, chk_total);
    $fatal(1);
  end

endmodule
